sevseg_display_scheduler: RTL and testbench
===========================================

// Module: sevseg_display_scheduler
// PURPOSE
//  Scans and time-shares the 8-digit common-anode seven-segment display.
//  Generates the 3-bit digit select that drives the display decode/anode
//  stage at a fixed refresh rate. Arbitrates two requesters (A, B) that each
//  want the display. Ownership changes and data changes occur only on frame
//  boundaries, so a frame never shows a mix of two words.
// PARAMETERS
//  TICKS_PER_DIGIT  100000  clk cycles each digit stays selected (>=2)
//  MIN_HOLD_FRAMES  4       frames an owner keeps the display against a competing req (>=1)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   reset, synchronous, active-high
//  req_a        in   1   requester A wants the display (level)
//  data_a       in   32  requester A word, 8 hex nibbles, [3:0] = rightmost digit
//  req_b        in   1   requester B wants the display (level)
//  data_b       in   32  requester B word
//  grant_a      out  1   A currently owns the display
//  grant_b      out  1   B currently owns the display
//  data_out     out  32  word being displayed, stable for a whole frame
//  led_select   out  3   digit index 0..7 for display decode
//  blank_out    out  1   1 = no owner, display stage must be held in reset/blank
//  frame_done   out  1   1-cycle pulse on each frame boundary
// BEHAVIOUR
//  Reset (rst=1 at clk edge, any time, incl. mid-frame): tick counter=0,
//   led_select=0, state=IDLE, hold_cnt=0, last_owner=B, grant_a=grant_b=0,
//   data_out=0, blank_out=1, frame_done=0. Takes effect next edge; no partial frame survives.
//  Scan: tick counter counts 0..TICKS_PER_DIGIT-1 and then wraps.
//   tick = (counter==TICKS_PER_DIGIT-1).
//   On tick, led_select increments mod 8 (7 -> 0 wraps).
//   Frame boundary fb = tick && led_select==7.
//   frame_done is registered and is 1 in the cycle after fb, i.e. coincident
//   with led_select==0. The scan runs continuously, including in IDLE.
//  States: IDLE, OWN_A, OWN_B. All outputs are registered.
//   grant_a=(state==OWN_A), grant_b=(state==OWN_B), blank_out=(state==IDLE).
//  Transitions are evaluated only when fb=1; at all other cycles, state,
//  data_out and hold_cnt hold their values.
//   IDLE: req_a&req_b -> owner = !last_owner. Only one req -> that one.
//    No req -> stay in IDLE.
//   OWN_X: frames = hold_cnt+1.
//    !req_X: if the other requester is requesting -> other owner, else -> IDLE.
//    req_X && other req && frames>=MIN_HOLD_FRAMES -> other owner.
//    Otherwise stay, hold_cnt = min(frames, MIN_HOLD_FRAMES).
//   On entering OWN_X: hold_cnt=0, last_owner=X.
//  data_out load at fb: data_a if next state is OWN_A, data_b if OWN_B,
//   32'h0 if IDLE. The value is sampled in the fb cycle, so changes to
//   data_X mid-frame appear at the next boundary.
//  A req dropped mid-frame keeps its grant and data until the next fb.
//  A req that pulses high only between two fbs is never seen (level protocol).
//  Latency: req asserted in IDLE -> grant/data_out valid <= 8*TICKS_PER_DIGIT cycles.
// TESTING (bench uses TICKS_PER_DIGIT=2, MIN_HOLD_FRAMES=2; frame = 16 cycles)
//  1 Reset, no reqs, run 40 cycles -> led_select 0,0,1,1..7,7,0 repeats;
//    frame_done high at cycles 16,32; blank_out=1; data_out=0.
//  2 req_a=1, data_a=32'h1234_5678 mid-frame -> grant_a=1, data_out=12345678
//    on the cycle after the next fb; change data_a to 32'hCAFE mid-frame ->
//    data_out changes only at the following fb.
//  3 From IDLE, raise req_a and req_b together -> A granted first
//    (last_owner=B after reset); after 2 owned frames, grant moves to B;
//    after 2 more frames, it returns to A.
//  4 Owner A drops req mid-frame, no B req -> grant_a stays until fb, then
//    IDLE, blank_out=1, data_out=0; A drops while B requests -> B granted at that fb.
//  5 Assert rst at led_select==5 while OWN_B -> next cycle all outputs are at
//    reset values; after deassertion, scan restarts from led_select=0 with a
//    full 16-cycle frame.

Source files
------------

// File: rtl/sevseg_display_scheduler.sv
// Scans an 8-digit seven-segment display and time-shares it between two
// requesters, switching owner and displayed word only on frame boundaries.
module sevseg_display_scheduler #(
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int MIN_HOLD_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [31:0] data_a,
    input  logic        req_b,
    input  logic [31:0] data_b,
    output logic        grant_a,
    output logic        grant_b,
    output logic [31:0] data_out,
    output logic [2:0]  led_select,
    output logic        blank_out,
    output logic        frame_done
);

    localparam int CNT_W  = $clog2(TICKS_PER_DIGIT);
    localparam int HOLD_W = $clog2(MIN_HOLD_FRAMES + 1);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [HOLD_W:0]  HOLD_MIN  = (HOLD_W + 1)'(MIN_HOLD_FRAMES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OWN_A = 2'd1;
    localparam logic [1:0] S_OWN_B = 2'd2;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic              fb;

    logic [1:0]        state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [HOLD_W:0]   frames;
    logic              last_owner, last_nxt;
    logic [31:0]       data_nxt;

    assign tick = (tick_cnt == TICK_LAST);
    assign fb   = tick && (led_select == 3'd7);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt   <= '0;
            led_select <= 3'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= fb;
            if (tick) begin
                tick_cnt   <= '0;
                led_select <= led_select + 3'd1;
            end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        last_nxt  = last_owner;
        frames    = {1'b0, hold_cnt} + (HOLD_W + 1)'(1);
        data_nxt  = 32'h0;

        case (state)
            S_IDLE: begin
                if (req_a && req_b)
                    state_nxt = (last_owner == OWNER_B) ? S_OWN_A : S_OWN_B;
                else if (req_a)
                    state_nxt = S_OWN_A;
                else if (req_b)
                    state_nxt = S_OWN_B;
            end
            S_OWN_A: begin
                if (!req_a)
                    state_nxt = req_b ? S_OWN_B : S_IDLE;
                else if (req_b && frames >= HOLD_MIN)
                    state_nxt = S_OWN_B;
                else
                    hold_nxt = (frames >= HOLD_MIN) ? HOLD_MIN[HOLD_W-1:0] : frames[HOLD_W-1:0];
            end
            S_OWN_B: begin
                if (!req_b)
                    state_nxt = req_a ? S_OWN_A : S_IDLE;
                else if (req_a && frames >= HOLD_MIN)
                    state_nxt = S_OWN_A;
                else
                    hold_nxt = (frames >= HOLD_MIN) ? HOLD_MIN[HOLD_W-1:0] : frames[HOLD_W-1:0];
            end
            default: state_nxt = S_IDLE;
        endcase

        // A fresh owner starts its minimum-hold window from zero.
        if (state_nxt == S_OWN_A && state != S_OWN_A) begin
            hold_nxt = '0;
            last_nxt = OWNER_A;
        end else if (state_nxt == S_OWN_B && state != S_OWN_B) begin
            hold_nxt = '0;
            last_nxt = OWNER_B;
        end

        if (state_nxt == S_OWN_A)
            data_nxt = data_a;
        else if (state_nxt == S_OWN_B)
            data_nxt = data_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            hold_cnt   <= '0;
            last_owner <= OWNER_B;
            grant_a    <= 1'b0;
            grant_b    <= 1'b0;
            data_out   <= 32'h0;
            blank_out  <= 1'b1;
        end else if (fb) begin
            state      <= state_nxt;
            hold_cnt   <= hold_nxt;
            last_owner <= last_nxt;
            grant_a    <= (state_nxt == S_OWN_A);
            grant_b    <= (state_nxt == S_OWN_B);
            data_out   <= data_nxt;
            blank_out  <= (state_nxt == S_IDLE);
        end
    end

endmodule

// File: tb/tb_sevseg_display_scheduler.sv
// Directed bench for sevseg_display_scheduler with a 16-cycle frame
// (2 ticks per digit, minimum hold of 2 frames).
module tb_sevseg_display_scheduler;

    logic        clk;
    logic        rst;
    logic        req_a, req_b;
    logic [31:0] data_a, data_b;
    logic        grant_a, grant_b;
    logic [31:0] data_out;
    logic [2:0]  led_select;
    logic        blank_out;
    logic        frame_done;

    int total;
    int bad;
    int n;

    sevseg_display_scheduler #(
        .TICKS_PER_DIGIT(2),
        .MIN_HOLD_FRAMES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_a      (req_a),
        .data_a     (data_a),
        .req_b      (req_b),
        .data_b     (data_b),
        .grant_a    (grant_a),
        .grant_b    (grant_b),
        .data_out   (data_out),
        .led_select (led_select),
        .blank_out  (blank_out),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          wait_cyc;
        logic        ra;
        logic        rb;
        logic [31:0] da;
        logic [31:0] db;
        logic        ga;
        logic        gb;
        logic [31:0] dout;
        logic        blank;
    } vec_t;

    vec_t vecs [27];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, n);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n     = 0;

        // {wait, req_a, req_b, data_a, data_b, grant_a, grant_b, data_out, blank}
        // Arbitration with both requesting, starting from IDLE after reset.
        vecs[0]  = '{7,  1, 1, 32'hA1A1A1A1, 32'hB2B2B2B2, 0, 0, 32'h0,        1}; // n=47
        vecs[1]  = '{1,  1, 1, 32'hA1A1A1A1, 32'hB2B2B2B2, 1, 0, 32'hA1A1A1A1, 0}; // n=48
        vecs[2]  = '{16, 1, 1, 32'hA1A1A1A1, 32'hB2B2B2B2, 1, 0, 32'hA1A1A1A1, 0}; // n=64
        vecs[3]  = '{15, 1, 1, 32'hA1A1A1A1, 32'hB2B2B2B2, 1, 0, 32'hA1A1A1A1, 0}; // n=79
        vecs[4]  = '{1,  1, 1, 32'hA1A1A1A1, 32'hB2B2B2B2, 0, 1, 32'hB2B2B2B2, 0}; // n=80
        vecs[5]  = '{16, 1, 1, 32'hA1A1A1A1, 32'hB2B2B2B2, 0, 1, 32'hB2B2B2B2, 0}; // n=96
        vecs[6]  = '{15, 1, 1, 32'hA1A1A1A1, 32'hB2B2B2B2, 0, 1, 32'hB2B2B2B2, 0}; // n=111
        vecs[7]  = '{1,  1, 1, 32'hA1A1A1A1, 32'hB2B2B2B2, 1, 0, 32'hA1A1A1A1, 0}; // n=112
        vecs[8]  = '{2,  1, 1, 32'hA1A1A1A1, 32'hB2B2B2B2, 1, 0, 32'hA1A1A1A1, 0}; // n=114
        // Owner A drops while B requests: B takes over at the boundary.
        vecs[9]  = '{13, 0, 1, 32'hA1A1A1A1, 32'hB2B2B2B2, 1, 0, 32'hA1A1A1A1, 0}; // n=127
        vecs[10] = '{1,  0, 1, 32'hA1A1A1A1, 32'hB2B2B2B2, 0, 1, 32'hB2B2B2B2, 0}; // n=128
        vecs[11] = '{15, 0, 0, 32'hA1A1A1A1, 32'hB2B2B2B2, 0, 1, 32'hB2B2B2B2, 0}; // n=143
        vecs[12] = '{1,  0, 0, 32'hA1A1A1A1, 32'hB2B2B2B2, 0, 0, 32'h0,        1}; // n=144
        // Mid-frame request and mid-frame data change.
        vecs[13] = '{6,  0, 0, 32'hA1A1A1A1, 32'hB2B2B2B2, 0, 0, 32'h0,        1}; // n=150
        vecs[14] = '{9,  1, 0, 32'h12345678, 32'hB2B2B2B2, 0, 0, 32'h0,        1}; // n=159
        vecs[15] = '{1,  1, 0, 32'h12345678, 32'hB2B2B2B2, 1, 0, 32'h12345678, 0}; // n=160
        vecs[16] = '{2,  1, 0, 32'h12345678, 32'hB2B2B2B2, 1, 0, 32'h12345678, 0}; // n=162
        vecs[17] = '{13, 1, 0, 32'h0000CAFE, 32'hB2B2B2B2, 1, 0, 32'h12345678, 0}; // n=175
        vecs[18] = '{1,  1, 0, 32'h0000CAFE, 32'hB2B2B2B2, 1, 0, 32'h0000CAFE, 0}; // n=176
        vecs[19] = '{2,  1, 0, 32'h0000CAFE, 32'hB2B2B2B2, 1, 0, 32'h0000CAFE, 0}; // n=178
        // Owner A drops alone: grant held until the boundary, then blank.
        vecs[20] = '{13, 0, 0, 32'h0000CAFE, 32'hB2B2B2B2, 1, 0, 32'h0000CAFE, 0}; // n=191
        vecs[21] = '{1,  0, 0, 32'h0000CAFE, 32'hB2B2B2B2, 0, 0, 32'h0,        1}; // n=192
        // A request pulse that never spans a boundary is ignored.
        vecs[22] = '{2,  0, 0, 32'h0000CAFE, 32'hB2B2B2B2, 0, 0, 32'h0,        1}; // n=194
        vecs[23] = '{4,  1, 0, 32'h0000CAFE, 32'hB2B2B2B2, 0, 0, 32'h0,        1}; // n=198
        vecs[24] = '{10, 0, 0, 32'h0000CAFE, 32'hB2B2B2B2, 0, 0, 32'h0,        1}; // n=208
        // B alone takes the display, ready for the mid-frame reset.
        vecs[25] = '{16, 0, 1, 32'h0000CAFE, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0}; // n=224
        vecs[26] = '{10, 0, 1, 32'h0000CAFE, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0}; // n=234

        rst    = 1'b1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        data_a = 32'h0;
        data_b = 32'h0;
        repeat (2) step();
        rst = 1'b0;

        check("reset led_select", 32'(led_select), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset blank_out",  32'(blank_out),  32'd1);
        check("reset grants",     32'({grant_a, grant_b}), 32'd0);
        check("reset data_out",   data_out, 32'h0);

        // Idle scan: two cycles per digit, frame_done coincident with digit 0.
        for (int i = 1; i <= 40; i++) begin
            step();
            n = i;
            check($sformatf("scan%0d led_select", i), 32'(led_select), 32'((i / 2) % 8));
            check($sformatf("scan%0d frame_done", i), 32'(frame_done), 32'(i % 16 == 0));
            check($sformatf("scan%0d blank_out", i),  32'(blank_out),  32'd1);
            check($sformatf("scan%0d data_out", i),   data_out, 32'h0);
        end

        for (int i = 0; i < 27; i++) begin
            req_a  = vecs[i].ra;
            req_b  = vecs[i].rb;
            data_a = vecs[i].da;
            data_b = vecs[i].db;
            repeat (vecs[i].wait_cyc) step();
            n = n + vecs[i].wait_cyc;
            check($sformatf("vec%0d grant_a", i),   32'(grant_a),   32'(vecs[i].ga));
            check($sformatf("vec%0d grant_b", i),   32'(grant_b),   32'(vecs[i].gb));
            check($sformatf("vec%0d data_out", i),  data_out,       vecs[i].dout);
            check($sformatf("vec%0d blank_out", i), 32'(blank_out), 32'(vecs[i].blank));
        end

        // Reset while B owns the display and digit 5 is selected.
        check("pre-reset led_select", 32'(led_select), 32'd5);
        rst = 1'b1;
        step();
        n = 0;
        check("midreset grant_a",    32'(grant_a),    32'd0);
        check("midreset grant_b",    32'(grant_b),    32'd0);
        check("midreset data_out",   data_out,        32'h0);
        check("midreset blank_out",  32'(blank_out),  32'd1);
        check("midreset frame_done", 32'(frame_done), 32'd0);
        check("midreset led_select", 32'(led_select), 32'd0);
        rst = 1'b0;

        // B still requesting: a full 16-cycle frame passes before the grant.
        repeat (15) step();
        n = 15;
        check("restart15 led_select", 32'(led_select), 32'd7);
        check("restart15 frame_done", 32'(frame_done), 32'd0);
        check("restart15 grant_b",    32'(grant_b),    32'd0);
        check("restart15 blank_out",  32'(blank_out),  32'd1);
        step();
        n = 16;
        check("restart16 led_select", 32'(led_select), 32'd0);
        check("restart16 frame_done", 32'(frame_done), 32'd1);
        check("restart16 grant_b",    32'(grant_b),    32'd1);
        check("restart16 data_out",   data_out,        32'hDEADBEEF);
        check("restart16 blank_out",  32'(blank_out),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
